call_stack: RTL

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack_if.sv | 28 ++
 rtl/call_stack.sv | 64 ++++++
 2 files changed

// File: rtl/call_stack_if.sv
// Push/pop request bus and stack status outputs for call_stack.
// The stack side uses the slave modport; the requester uses master.
interface call_stack_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             err_clr;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, push_data, err_clr,
    input  top_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output top_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// Return-address stack: DEPTH x WIDTH registers, count doubles as the stack
// pointer, combinational top-of-stack, sticky overflow/underflow flags.
module call_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  call_stack_if.slave  bus
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [CW-1:0]               count;
  logic                        overflow, underflow;
  logic                        empty, full;
  logic [CW-1:0]               count_m1;
  logic [AW-1:0]               top_idx, wr_idx;
  logic                        wr_en, inc, dec, ovf_set, udf_set;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign count_m1 = count - CW'(1);
  assign top_idx  = count_m1[AW-1:0];

  // Empty must read as zero so stale storage never leaks past a reset or pops.
  assign bus.top_data  = empty ? '0 : mem[top_idx];
  assign bus.count     = count;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

  // push+pop on a non-empty stack rewrites the top slot; otherwise a push
  // lands at slot[count] (slot 0 when a push+pop hits an empty stack).
  assign wr_en   = bus.push & (bus.pop | ~full);
  assign wr_idx  = (bus.pop && !empty) ? top_idx : count[AW-1:0];
  assign inc     = bus.push & (bus.pop ? empty : ~full);
  assign dec     = bus.pop & ~bus.push & ~empty;
  assign ovf_set = bus.push & ~bus.pop & full;
  assign udf_set = bus.pop & empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus.push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (inc)      count <= count + CW'(1);
      else if (dec) count <= count - CW'(1);
      // A new error in the same cycle as err_clr keeps the flag set.
      if (ovf_set)          overflow  <= 1'b1;
      else if (bus.err_clr) overflow  <= 1'b0;
      if (udf_set)          underflow <= 1'b1;
      else if (bus.err_clr) underflow <= 1'b0;
    end
  end

endmodule
